// File: rtl/ysyx_24080014_mem_arb_if.sv
// ----------------------------------------------------------------------------
// ysyx_24080014_mem_arb_if
// Purpose : Bundles the IFU, LSU and shared memory-port signals of the memory
//           arbiter into one interface so the arbiter and its environment
//           connect through a single port.
// Signals :
//   IFU  : if_req, if_addr (to arbiter); if_resp, if_rdata, if_err (from it)
//   LSU  : ls_req, ls_wen, ls_addr, ls_wdata, ls_wmask (to arbiter);
//          ls_resp, ls_rdata, ls_err (from it)
//   MEM  : m_ren, m_wen, m_valid, m_raddr, m_waddr, m_wdata, m_wmask (from
//          arbiter); m_ready, m_rdata (to arbiter)
//   STAT : grant, busy (from arbiter)
// Modports:
//   slave  - the arbiter's view (requests and memory completion are inputs)
//   master - the environment's view (requesters plus memory device)
// ----------------------------------------------------------------------------
interface ysyx_24080014_mem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // IFU side (read-only requester)
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_resp;
  logic [DW-1:0] if_rdata;
  logic          if_err;

  // LSU side (read/write requester)
  logic          ls_req;
  logic          ls_wen;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic [7:0]    ls_wmask;
  logic          ls_resp;
  logic [DW-1:0] ls_rdata;
  logic          ls_err;

  // Shared memory-access port
  logic          m_ren;
  logic          m_wen;
  logic          m_valid;
  logic [AW-1:0] m_raddr;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [7:0]    m_wmask;
  logic          m_ready;
  logic [DW-1:0] m_rdata;

  // Status
  logic [1:0]    grant;
  logic          busy;

  modport slave (
    input  if_req, if_addr,
    output if_resp, if_rdata, if_err,
    input  ls_req, ls_wen, ls_addr, ls_wdata, ls_wmask,
    output ls_resp, ls_rdata, ls_err,
    output m_ren, m_wen, m_valid, m_raddr, m_waddr, m_wdata, m_wmask,
    input  m_ready, m_rdata,
    output grant, busy
  );

  modport master (
    output if_req, if_addr,
    input  if_resp, if_rdata, if_err,
    output ls_req, ls_wen, ls_addr, ls_wdata, ls_wmask,
    input  ls_resp, ls_rdata, ls_err,
    input  m_ren, m_wen, m_valid, m_raddr, m_waddr, m_wdata, m_wmask,
    output m_ready, m_rdata,
    input  grant, busy
  );
endinterface

// File: rtl/ysyx_24080014_mem_arb.sv
// ----------------------------------------------------------------------------
// ysyx_24080014_mem_arb
// Purpose : Arbitrates the single multi-cycle memory-access port between the
//           IFU (reads only) and the LSU (reads and writes). Each transaction
//           runs IDLE -> ISSUE -> WAIT -> RESP: the winner's request is
//           latched in IDLE, a one-cycle start is sent in ISSUE, WAIT holds
//           until m_ready or a timeout, and RESP pulses the owner's response.
// Ports   :
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-high reset; abandons any transaction
//   bus  - ysyx_24080014_mem_arb_if.slave (IFU, LSU, memory and status)
// Params  :
//   TIMEOUT - WAIT cycles without m_ready before abort with error (2..255)
//   AW, DW  - address / data width; must match the connected interface
// Config  :
//   YSYX_ARB_RR_EN - when defined, simultaneous requests are granted
//                    round-robin using last_grant; otherwise the LSU always
//                    wins (last_grant is still tracked).
// ----------------------------------------------------------------------------
module ysyx_24080014_mem_arb #(
  parameter int TIMEOUT = 64,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  ysyx_24080014_mem_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Grant code doubles as the owner of the transaction in flight.
  typedef enum logic [1:0] {
    G_NONE = 2'b00,
    G_IFU  = 2'b01,
    G_LSU  = 2'b10
  } grant_e;

  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

  // The counter reaches at most TIMEOUT-1, which fits 8 bits for TIMEOUT<=255.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e        state_q, state_d;
  grant_e        grant_q, grant_d;
  req_e          last_grant_q, last_grant_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [7:0]    wmask_q, wmask_d;
  logic          wen_q, wen_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          lsu_wins;
  logic          timed_out;

  // --------------------------------------------------------------------------
  // Winner selection, only meaningful in IDLE with at least one request.
  // --------------------------------------------------------------------------
`ifdef YSYX_ARB_RR_EN
  // A lone requester always wins; on a tie the one not served last wins.
  assign lsu_wins = bus.ls_req && (!bus.if_req || (last_grant_q == REQ_IFU));
`else
  // Fixed priority: any LSU request beats the IFU.
  assign lsu_wins = bus.ls_req;
`endif

  // m_ready has priority over a timeout landing on the same cycle.
  assign timed_out = (cnt_q == CNT_LAST) && !bus.m_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= G_NONE;
      last_grant_q <= REQ_IFU;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      wen_q        <= 1'b0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      wen_q        <= wen_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a hold default first so no path through the
    // case can leave one unassigned and infer a latch.
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    wen_d        = wen_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    err_d        = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.if_req || bus.ls_req) begin
          if (lsu_wins) begin
            grant_d      = G_LSU;
            last_grant_d = REQ_LSU;
            addr_d       = bus.ls_addr;
            wdata_d      = bus.ls_wdata;
            wmask_d      = bus.ls_wmask;
            wen_d        = bus.ls_wen;
          end else begin
            // The IFU only ever reads; write fields are cleared.
            grant_d      = G_IFU;
            last_grant_d = REQ_IFU;
            addr_d       = bus.if_addr;
            wdata_d      = '0;
            wmask_d      = '0;
            wen_d        = 1'b0;
          end
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.m_ready) begin
          rdata_d = wen_q ? '0 : bus.m_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timed_out) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        grant_d = G_NONE;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        grant_d = G_NONE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from state and the latched transaction, so reset
  // clears them immediately.
  // --------------------------------------------------------------------------
  logic in_issue;
  logic in_resp;
  logic resp_if;
  logic resp_ls;

  assign in_issue = (state_q == S_ISSUE);
  assign in_resp  = (state_q == S_RESP);
  assign resp_if  = in_resp && (grant_q == G_IFU);
  assign resp_ls  = in_resp && (grant_q == G_LSU);

  assign bus.m_ren   = in_issue && !wen_q;
  assign bus.m_wen   = in_issue &&  wen_q;
  assign bus.m_valid = (state_q == S_WAIT);
  assign bus.m_raddr = addr_q;
  assign bus.m_waddr = addr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.m_wmask = wmask_q;

  assign bus.if_resp  = resp_if;
  assign bus.if_rdata = resp_if ? rdata_q : '0;
  assign bus.if_err   = resp_if && err_q;

  assign bus.ls_resp  = resp_ls;
  assign bus.ls_rdata = resp_ls ? rdata_q : '0;
  assign bus.ls_err   = resp_ls && err_q;

  assign bus.grant = grant_q;
  assign bus.busy  = (state_q != S_IDLE);

endmodule

// File: doc/ysyx_24080014_mem_arb.md
Name: ysyx_24080014_mem_arb

Overview:
Arbitrates between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write) for the single shared memory-access port. The port is a multi-cycle device: it takes a start request and later returns a ready pulse. The block sequences each transaction as capture, issue, wait and respond, and returns read data to the winning requester. It sits between IFU/LSU and the memory-access block and detects hung transactions with a timeout.

Parameters:
TIMEOUT, 64, WAIT-state cycles without m_ready before the transaction is aborted with an error (legal range 2..255)
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
if_req  in  1  IFU read request; held until if_resp
if_addr  in  AW  IFU read address
if_resp  out  1  one-cycle pulse: IFU transaction complete
if_rdata  out  DW  IFU read data, valid with if_resp
if_err  out  1  valid with if_resp; 1 = timed out
ls_req  in  1  LSU request; held until ls_resp
ls_wen  in  1  1 = write, 0 = read
ls_addr  in  AW  LSU address
ls_wdata  in  DW  LSU write data
ls_wmask  in  8  LSU write byte mask
ls_resp  out  1  one-cycle pulse: LSU transaction complete
ls_rdata  out  DW  LSU read data (0 for writes)
ls_err  out  1  valid with ls_resp; 1 = timed out
m_ren  out  1  one-cycle read start to memory
m_wen  out  1  one-cycle write start to memory
m_valid  out  1  high from cycle after start until m_ready; blocks memory re-launch
m_raddr  out  AW  memory read address
m_waddr  out  AW  memory write address
m_wdata  out  DW  memory write data
m_wmask  out  8  memory write mask
m_ready  in  1  memory completion
m_rdata  in  DW  memory read data, valid with m_ready
grant  out  2  01 = IFU owns port, 10 = LSU owns, 00 = idle
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, immediate): state = IDLE. All outputs 0; latched address/data/mask/owner/wen = 0; timeout counter = 0; last_grant = IFU.
- Reset during a transaction abandons it. No response is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any request is present, select a winner and latch its address, wdata, wmask and wen into internal registers. A read by IFU always has wen = 0.
  - Set grant to the winner, update last_grant, go to ISSUE.
  - If there is no request, stay in IDLE.
- Winner selection with both requests present: LSU wins (fixed priority; see Optional Feature).
- ISSUE (exactly 1 cycle):
  - Assert m_wen if latched wen = 1, else assert m_ren.
  - m_raddr and m_waddr both drive the latched address. m_wdata and m_wmask drive the latched values.
  - Clear the counter, go to WAIT.
- WAIT:
  - m_ren and m_wen are 0, m_valid = 1, and address/data outputs are held stable.
  - Counter increments each cycle.
  - On m_ready: capture m_rdata (forced to 0 for writes), err = 0, go to RESP.
  - If the counter reaches TIMEOUT-1 without m_ready: rdata = 0, err = 1, go to RESP.
  - If m_ready and timeout occur in the same cycle, m_ready wins and err = 0.
- RESP (exactly 1 cycle):
  - Pulse the owner's resp with its rdata and err. The other requester's outputs stay 0.
  - m_valid = 0. Clear grant, go to IDLE.
- Minimum latency is 4 cycles from req sampled to resp, when m_ready arrives on the first WAIT cycle.
- Back-to-back: a requester holding req through its own resp cycle is re-arbitrated in the next IDLE cycle. The requester must drop req in the cycle after resp if it wants no repeat.
- m_ready seen in IDLE, ISSUE or RESP is ignored.
- A requester dropping req mid-transaction does not cancel it; the resp pulse still occurs.
- Request-side inputs are sampled only in IDLE; later changes have no effect on the latched transaction.

Optional Feature:
YSYX_ARB_RR_EN
- Defined: round-robin. When both requests are present in IDLE, grant goes to the requester not recorded in last_grant. A single requester always wins regardless of last_grant.
- Undefined: fixed priority, LSU always beats IFU. last_grant is still maintained but unused.

Test Plan:
- IFU only, if_addr=0x80000000, m_ready on 1st WAIT cycle, m_rdata=0x00000413 -> m_ren pulse in ISSUE, if_resp on cycle 4 with if_rdata=0x00000413, if_err=0, grant=01 during transaction.
- LSU write addr=0x80001000, wdata=0xCAFEBABE, wmask=0x0F -> single m_wen pulse with those values, m_valid high until m_ready, ls_resp with ls_rdata=0, ls_err=0.
- IFU and LSU requesting together, both held across 2 transactions -> macro off: LSU, LSU; macro on: LSU, IFU.
- m_ready never asserted, TIMEOUT=8 -> owner resp after 8 WAIT cycles, err=1, rdata=0, block returns to IDLE and serves the next request normally.
- rst asserted mid-WAIT, then m_ready pulsed after release -> no resp pulse; all outputs 0 immediately; stray m_ready ignored in IDLE.
- m_ready and timeout coincide (ready on cycle TIMEOUT-1) -> err=0, rdata=m_rdata.
